// File: rtl/inst_fetch_queue_if.sv
// Fetch unit bundle: redirect input, instruction-memory request/response
// channel, and the decode-side instruction handshake.
// master = fetch queue, slave = its environment (memory + decode + branch unit).
interface inst_fetch_queue_if #(
    parameter int DBITS               = 32,
    parameter int IMEM_ADDR_BIT_WIDTH = 11
);
    logic                           redirect;
    logic [DBITS-1:0]               redirectPc;
    logic                           memReq;
    logic [IMEM_ADDR_BIT_WIDTH-1:0] memAddr;
    logic                           memReady;
    logic                           memRdValid;
    logic [DBITS-1:0]               memRdData;
    logic                           instValid;
    logic [DBITS-1:0]               instWord;
    logic [DBITS-1:0]               instPc;
    logic                           instReady;

    modport master (
        input  redirect, redirectPc, memReady, memRdValid, memRdData, instReady,
        output memReq, memAddr, instValid, instWord, instPc
    );

    modport slave (
        output redirect, redirectPc, memReady, memRdValid, memRdData, instReady,
        input  memReq, memAddr, instValid, instWord, instPc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time to instruction
// memory, buffers returned words with their PCs in a small FIFO, and flushes
// everything on a redirect. A fetch is only issued when the FIFO is guaranteed
// to have room for its response, so a push can never overflow.
module inst_fetch_queue #(
    parameter int               DBITS               = 32,
    parameter logic [DBITS-1:0] START_PC            = 'h40,
    parameter int               DEPTH               = 4,
    parameter int               IMEM_ADDR_BIT_WIDTH = 11
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [DBITS-1:0] WORD_MASK = ~DBITS'(3);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state_q,    state_d;
    logic [DBITS-1:0] fetch_pc_q, fetch_pc_d;   // next address to request
    logic [DBITS-1:0] req_pc_q,   req_pc_d;     // PC of the outstanding request
    logic             mem_req_q,  mem_req_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_after;

    logic [DBITS-1:0] word_mem [DEPTH];
    logic [DBITS-1:0] pc_mem   [DEPTH];

    // Next-state logic: FSM, fetch PC and FIFO bookkeeping; redirect overrides all
    always_comb begin
        pop         = (count_q != '0) && bus.instReady && !bus.redirect;
        push        = (state_q == WAIT) && bus.memRdValid && !bus.redirect;
        count_after = count_q + CNT_W'(push) - CNT_W'(pop);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                // Nothing is outstanding here, so a free slot is enough to issue.
                if (bus.redirect || (count_q < DEPTH_C)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    // An accepted request must have its response swallowed.
                    state_d = bus.memReady ? DROP : REQ;
                end else if (bus.memReady) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + DBITS'(4);
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    state_d = bus.memRdValid ? IDLE : DROP;
                end else if (bus.memRdValid) begin
                    state_d = (count_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.memRdValid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = bus.redirectPc & WORD_MASK;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_after;
        end

        mem_req_d = (state_d == REQ);
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= START_PC & WORD_MASK;
            req_pc_q   <= '0;
            mem_req_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            mem_req_q  <= mem_req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= bus.memRdData;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign bus.memReq    = mem_req_q;
    assign bus.memAddr   = fetch_pc_q[IMEM_ADDR_BIT_WIDTH+1:2];
    assign bus.instValid = (count_q != '0);
    assign bus.instWord  = (count_q != '0) ? word_mem[rd_ptr_q] : '0;
    assign bus.instPc    = (count_q != '0) ? pc_mem[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue. A simple memory model answers accepted
// requests one cycle later with data 0xC0000000 | word_address.
module tb_inst_fetch_queue;
    localparam int DBITS = 32;
    localparam int AW    = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DBITS(DBITS), .IMEM_ADDR_BIT_WIDTH(AW)) bus ();

    inst_fetch_queue #(
        .DBITS(DBITS), .START_PC(32'h40), .DEPTH(4), .IMEM_ADDR_BIT_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    bit auto_mem = 1'b0;
    logic [AW-1:0] issued_q [$];

    // One clock: note any request transfer at this edge, then let the memory
    // model answer it in the following cycle.
    task automatic tick();
        logic          acc;
        logic [AW-1:0] a;
        acc = bus.memReq && bus.memReady;
        a   = bus.memAddr;
        @(posedge clk);
        #1;
        if (acc) issued_q.push_back(a);
        if (auto_mem) begin
            bus.memRdValid = acc;
            bus.memRdData  = acc ? (32'hC000_0000 | 32'(a)) : 32'h0;
        end
    endtask

    task automatic wait_inst(input string tag, output int n);
        n = 0;
        while (!bus.instValid && n < 40) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (bus.instValid !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_timeout: instValid=%0b required 1", tag, bus.instValid);
        end
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        int s0 = issued_q.size();
        while (issued_q.size() == s0 && n < 20) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (issued_q.size() == s0) begin
            err_cnt++;
            $display("FAIL %s_accept_timeout: no request accepted, required one", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.redirect = 1'b0; bus.redirectPc = '0; bus.memReady = 1'b1;
        bus.memRdValid = 1'b0; bus.memRdData = '0; bus.instReady = 1'b0;
        #2;
        tick(); tick();
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL rst_memReq: got %0b required 0", bus.memReq); end
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rst_instValid: got %0b required 0", bus.instValid); end
        vec_cnt++; if (bus.instWord !== 32'h0) begin err_cnt++; $display("FAIL rst_instWord: got %h required 0", bus.instWord); end
        vec_cnt++; if (bus.instPc !== 32'h0) begin err_cnt++; $display("FAIL rst_instPc: got %h required 0", bus.instPc); end
        vec_cnt++; if (bus.memAddr !== 11'h10) begin err_cnt++; $display("FAIL rst_memAddr: got %h required 010", bus.memAddr); end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        issued_q.delete();
        auto_mem = 1'b1;
        reset = 1'b1;
        repeat (20) tick();
        vec_cnt++; if (issued_q.size() != 4) begin err_cnt++; $display("FAIL fill_issue_count: got %0d required 4", issued_q.size()); end
        for (int i = 0; i < issued_q.size() && i < 4; i++) begin
            vec_cnt++;
            if (issued_q[i] !== AW'(16 + i)) begin
                err_cnt++; $display("FAIL fill_addr%0d: got %h required %h", i, issued_q[i], AW'(16 + i));
            end
        end
        vec_cnt++; if (bus.instValid !== 1'b1) begin err_cnt++; $display("FAIL fill_instValid: got %0b required 1", bus.instValid); end
        vec_cnt++; if (bus.instPc !== 32'h40) begin err_cnt++; $display("FAIL fill_instPc: got %h required 00000040", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_0010) begin err_cnt++; $display("FAIL fill_instWord: got %h required c0000010", bus.instWord); end
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL fill_memReq_full: got %0b required 0", bus.memReq); end
        vec_cnt++; if (bus.memAddr !== 11'h14) begin err_cnt++; $display("FAIL fill_memAddr: got %h required 014", bus.memAddr); end
        $display("test_fill done");
    endtask

    task automatic test_pop_one();
        issued_q.delete();
        bus.instReady = 1'b1;
        tick();
        bus.instReady = 1'b0;
        vec_cnt++; if (bus.instPc !== 32'h44) begin err_cnt++; $display("FAIL pop_instPc: got %h required 00000044", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_0011) begin err_cnt++; $display("FAIL pop_instWord: got %h required c0000011", bus.instWord); end
        repeat (10) tick();
        vec_cnt++; if (issued_q.size() != 1) begin err_cnt++; $display("FAIL pop_issue_count: got %0d required 1", issued_q.size()); end
        if (issued_q.size() > 0) begin
            vec_cnt++; if (issued_q[0] !== 11'h14) begin err_cnt++; $display("FAIL pop_addr: got %h required 014", issued_q[0]); end
        end
        vec_cnt++; if (bus.instPc !== 32'h44) begin err_cnt++; $display("FAIL pop_head_after: got %h required 00000044", bus.instPc); end
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL pop_memReq_full: got %0b required 0", bus.memReq); end
        $display("test_pop_one done");
    endtask

    task automatic test_redirect_wait();
        int n;
        auto_mem = 1'b0;
        bus.memRdValid = 1'b0;
        bus.instReady = 1'b1;
        tick();
        bus.instReady = 1'b0;
        issued_q.delete();
        wait_accept("rdw");
        bus.redirect = 1'b1; bus.redirectPc = 32'h203;
        tick();
        bus.redirect = 1'b0;
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rdw_flush: instValid=%0b required 0", bus.instValid); end
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL rdw_drop_memReq: got %0b required 0", bus.memReq); end
        vec_cnt++; if (bus.memAddr !== 11'h80) begin err_cnt++; $display("FAIL rdw_memAddr: got %h required 080", bus.memAddr); end
        bus.memRdValid = 1'b1; bus.memRdData = 32'hDEAD_BEEF;
        tick();
        bus.memRdValid = 1'b0;
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rdw_discard: instValid=%0b required 0", bus.instValid); end
        issued_q.delete();
        auto_mem = 1'b1;
        wait_inst("rdw", n);
        if (issued_q.size() > 0) begin
            vec_cnt++; if (issued_q[0] !== 11'h80) begin err_cnt++; $display("FAIL rdw_first_addr: got %h required 080", issued_q[0]); end
        end
        vec_cnt++; if (bus.instPc !== 32'h200) begin err_cnt++; $display("FAIL rdw_instPc: got %h required 00000200", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_0080) begin err_cnt++; $display("FAIL rdw_instWord: got %h required c0000080", bus.instWord); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        bus.instReady = 1'b0;
        repeat (20) tick();
        auto_mem = 1'b0;
        bus.memRdValid = 1'b0;
        bus.instReady = 1'b1;
        tick();
        bus.instReady = 1'b0;
        issued_q.delete();
        wait_accept("rsc");
        vec_cnt++; if (bus.instValid !== 1'b1) begin err_cnt++; $display("FAIL rsc_pre_valid: got %0b required 1", bus.instValid); end
        bus.redirect = 1'b1; bus.redirectPc = 32'h300;
        bus.memRdValid = 1'b1; bus.memRdData = 32'h1234_5678; bus.instReady = 1'b1;
        tick();
        bus.redirect = 1'b0; bus.memRdValid = 1'b0; bus.instReady = 1'b0;
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rsc_empty: instValid=%0b required 0", bus.instValid); end
        vec_cnt++; if (bus.instPc !== 32'h0) begin err_cnt++; $display("FAIL rsc_instPc_zero: got %h required 0", bus.instPc); end
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL rsc_idle_memReq: got %0b required 0", bus.memReq); end
        tick();
        vec_cnt++; if (bus.memReq !== 1'b1) begin err_cnt++; $display("FAIL rsc_req_memReq: got %0b required 1", bus.memReq); end
        vec_cnt++; if (bus.memAddr !== 11'hC0) begin err_cnt++; $display("FAIL rsc_memAddr: got %h required 0c0", bus.memAddr); end
        auto_mem = 1'b1;
        wait_inst("rsc", n);
        vec_cnt++; if (bus.instPc !== 32'h300) begin err_cnt++; $display("FAIL rsc_instPc: got %h required 00000300", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_00C0) begin err_cnt++; $display("FAIL rsc_instWord: got %h required c00000c0", bus.instWord); end
        $display("test_redirect_same_cycle done");
    endtask

    task automatic test_stall();
        int n;
        bus.instReady = 1'b0;
        repeat (20) tick();
        bus.memReady = 1'b0;
        bus.redirect = 1'b1; bus.redirectPc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if (bus.memReq !== 1'b1 || bus.memAddr !== 11'h40 || bus.instValid !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall_cycle%0d: memReq=%0b memAddr=%h instValid=%0b required 1/040/0",
                         i, bus.memReq, bus.memAddr, bus.instValid);
            end
            tick();
        end
        bus.memReady = 1'b1;
        wait_inst("stall", n);
        vec_cnt++; if (n != 2) begin err_cnt++; $display("FAIL stall_latency: got %0d cycles required 2", n); end
        vec_cnt++; if (bus.instPc !== 32'h100) begin err_cnt++; $display("FAIL stall_instPc: got %h required 00000100", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_0040) begin err_cnt++; $display("FAIL stall_instWord: got %h required c0000040", bus.instWord); end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (20) tick();
        auto_mem = 1'b0;
        bus.memRdValid = 1'b0;
        bus.instReady = 1'b1;
        tick();
        bus.instReady = 1'b0;
        issued_q.delete();
        wait_accept("rmid");
        reset = 1'b0;
        #1;
        vec_cnt++; if (bus.memReq !== 1'b0) begin err_cnt++; $display("FAIL rmid_memReq: got %0b required 0", bus.memReq); end
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rmid_instValid: got %0b required 0", bus.instValid); end
        vec_cnt++; if (bus.memAddr !== 11'h10) begin err_cnt++; $display("FAIL rmid_memAddr: got %h required 010", bus.memAddr); end
        tick(); tick();
        reset = 1'b1;
        bus.memRdValid = 1'b1; bus.memRdData = 32'hBAD0_BAD0;
        tick();
        bus.memRdValid = 1'b0;
        vec_cnt++; if (bus.instValid !== 1'b0) begin err_cnt++; $display("FAIL rmid_ignore: instValid=%0b required 0", bus.instValid); end
        vec_cnt++; if (bus.memReq !== 1'b1) begin err_cnt++; $display("FAIL rmid_restart: memReq=%0b required 1", bus.memReq); end
        issued_q.delete();
        auto_mem = 1'b1;
        wait_inst("rmid", n);
        if (issued_q.size() > 0) begin
            vec_cnt++; if (issued_q[0] !== 11'h10) begin err_cnt++; $display("FAIL rmid_first_addr: got %h required 010", issued_q[0]); end
        end
        vec_cnt++; if (bus.instPc !== 32'h40) begin err_cnt++; $display("FAIL rmid_instPc: got %h required 00000040", bus.instPc); end
        vec_cnt++; if (bus.instWord !== 32'hC000_0010) begin err_cnt++; $display("FAIL rmid_instWord: got %h required c0000010", bus.instWord); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_one();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
